// File: rtl/serial_frame_receiver.sv
// Serial-in, parallel-out frame receiver: start bit (0), WIDTH data bits MSB-first, stop bit (1).
// Good words are presented on q with a valid/ack handshake; framing errors and overruns are sticky.
module serial_frame_receiver #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             bit_en,
    input  logic             w,
    input  logic             ack,
    input  logic             err_clr,
    output logic [WIDTH-1:0] q,
    output logic             valid,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        STOP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               valid_q, valid_d;
    logic               frame_err_q, frame_err_d;
    logic               overrun_q, overrun_d;
    logic               good_stop;
    logic               bad_stop;
    logic               overrun_set;

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sh_d        = sh_q;
        q_d         = q_q;
        valid_d     = valid_q;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;
        good_stop   = 1'b0;
        bad_stop    = 1'b0;
        overrun_set = 1'b0;

        if (bit_en) begin
            case (state_q)
                IDLE: begin
                    if (!w) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end
                end
                DATA: begin
                    sh_d = {sh_q[WIDTH-2:0], w};
                    if (cnt_q == LAST_BIT) begin
                        state_d = STOP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    // A low stop bit is only an error; it never doubles as the next start bit.
                    state_d   = IDLE;
                    good_stop = w;
                    bad_stop  = ~w;
                end
                default: state_d = IDLE;
            endcase
        end

        if (valid_q && ack) begin
            valid_d = 1'b0;
        end

        if (good_stop) begin
            if (!valid_q || ack) begin
                q_d     = sh_q;
                valid_d = 1'b1;
            end else begin
                overrun_set = 1'b1;
            end
        end

        // Clear first so a same-cycle set takes priority.
        if (err_clr) begin
            frame_err_d = 1'b0;
            overrun_d   = 1'b0;
        end
        if (bad_stop) begin
            frame_err_d = 1'b1;
        end
        if (overrun_set) begin
            overrun_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update together from pre-edge values.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sh_q        <= '0;
            q_q         <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            q_q         <= q_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign q         = q_q;
    assign valid     = valid_q;
    assign busy      = (state_q != IDLE);
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed bench for serial_frame_receiver: a frame-level model checked every cycle plus literal spot checks.
module tb_serial_frame_receiver;

    localparam int W = 4;

    logic         clock;
    logic         resetn;
    logic         bit_en;
    logic         w;
    logic         ack;
    logic         err_clr;
    logic [W-1:0] q;
    logic         valid;
    logic         busy;
    logic         frame_err;
    logic         overrun;

    int n_checks = 0;
    int n_errors = 0;

    serial_frame_receiver #(.WIDTH(W)) dut (
        .clock    (clock),
        .resetn   (resetn),
        .bit_en   (bit_en),
        .w        (w),
        .ack      (ack),
        .err_clr  (err_clr),
        .q        (q),
        .valid    (valid),
        .busy     (busy),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: collect the bits of the current frame in a queue; the strobe after
    // WIDTH collected bits is the stop bit.
    logic         m_in_frame = 1'b0;
    logic         m_bits[$];
    logic [W-1:0] m_q = '0;
    logic         m_valid = 1'b0;
    logic         m_fe = 1'b0;
    logic         m_ov = 1'b0;

    always @(posedge clock) begin
        logic         good, bad, ov_set, nv;
        logic [W-1:0] word;
        #1;
        good = 1'b0;
        bad = 1'b0;
        ov_set = 1'b0;
        word = '0;
        if (!resetn) begin
            m_in_frame = 1'b0;
            m_bits.delete();
            m_q = '0;
            m_valid = 1'b0;
            m_fe = 1'b0;
            m_ov = 1'b0;
        end else begin
            if (bit_en) begin
                if (!m_in_frame) begin
                    if (!w) begin
                        m_in_frame = 1'b1;
                        m_bits.delete();
                    end
                end else if (m_bits.size() < W) begin
                    m_bits.push_back(w);
                end else begin
                    m_in_frame = 1'b0;
                    for (int i = 0; i < W; i++) word = (word << 1) | W'(m_bits[i]);
                    if (w) good = 1'b1;
                    else bad = 1'b1;
                end
            end
            nv = m_valid && !ack;
            if (good) begin
                if (!m_valid || ack) begin
                    m_q = word;
                    nv = 1'b1;
                end else begin
                    ov_set = 1'b1;
                end
            end
            if (err_clr) begin
                m_fe = 1'b0;
                m_ov = 1'b0;
            end
            if (bad) m_fe = 1'b1;
            if (ov_set) m_ov = 1'b1;
            m_valid = nv;
        end
        check("cyc_q", 32'(q), 32'(m_q));
        check("cyc_valid", 32'(valid), 32'(m_valid));
        check("cyc_busy", 32'(busy), 32'(m_in_frame));
        check("cyc_frame_err", 32'(frame_err), 32'(m_fe));
        check("cyc_overrun", 32'(overrun), 32'(m_ov));
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            bit_en = 1'b0;
            w = 1'b1;
            ack = 1'b0;
            err_clr = 1'b0;
        end
    endtask

    task automatic send_bit(input logic b, input int gap, input logic a, input logic c);
        @(negedge clock);
        bit_en = 1'b1;
        w = b;
        ack = a;
        err_clr = c;
        repeat (gap) begin
            @(negedge clock);
            bit_en = 1'b0;
            w = ~w;
            ack = 1'b0;
            err_clr = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [W-1:0] data, input logic stop, input int gap,
                              input logic ack_stop, input logic clr_stop);
        send_bit(1'b0, gap, 1'b0, 1'b0);
        for (int i = W - 1; i >= 0; i--) send_bit(data[i], gap, 1'b0, 1'b0);
        send_bit(stop, gap, ack_stop, clr_stop);
    endtask

    task automatic do_reset();
        @(negedge clock);
        resetn = 1'b0;
        bit_en = 1'b0;
        w = 1'b1;
        ack = 1'b0;
        err_clr = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn = 1'b0;
        bit_en = 1'b0;
        w = 1'b1;
        ack = 1'b0;
        err_clr = 1'b0;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        check("reset_q", 32'(q), 32'h0);
        check("reset_valid", 32'(valid), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_flags", 32'({frame_err, overrun}), 32'h0);

        // 1: good frame 1011 with a strobe every cycle
        send_frame(4'b1011, 1'b1, 0, 1'b0, 1'b0);
        idle(1);
        check("t1_q", 32'(q), 32'hB);
        check("t1_valid", 32'(valid), 32'h1);
        check("t1_frame_err", 32'(frame_err), 32'h0);
        check("t1_busy", 32'(busy), 32'h0);

        // 2: bad stop bit from reset, then clear the flag
        do_reset();
        send_frame(4'hF, 1'b0, 0, 1'b0, 1'b0);
        idle(1);
        check("t2_frame_err", 32'(frame_err), 32'h1);
        check("t2_valid", 32'(valid), 32'h0);
        check("t2_q", 32'(q), 32'h0);
        @(negedge clock);
        err_clr = 1'b1;
        idle(1);
        check("t2_cleared", 32'(frame_err), 32'h0);

        // 3a: two frames without ack -> overrun, first word kept
        do_reset();
        send_frame(4'hA, 1'b1, 0, 1'b0, 1'b0);
        idle(1);
        send_frame(4'h5, 1'b1, 0, 1'b0, 1'b0);
        idle(1);
        check("t3a_q", 32'(q), 32'hA);
        check("t3a_valid", 32'(valid), 32'h1);
        check("t3a_overrun", 32'(overrun), 32'h1);

        // 3b: ack on the second delivery cycle -> second word replaces first
        do_reset();
        send_frame(4'hA, 1'b1, 0, 1'b0, 1'b0);
        idle(1);
        send_frame(4'h5, 1'b1, 0, 1'b1, 1'b0);
        idle(1);
        check("t3b_q", 32'(q), 32'h5);
        check("t3b_valid", 32'(valid), 32'h1);
        check("t3b_overrun", 32'(overrun), 32'h0);

        // 4: strobe every 3rd cycle, line toggling between strobes
        do_reset();
        send_frame(4'b1011, 1'b1, 2, 1'b0, 1'b0);
        idle(1);
        check("t4_q", 32'(q), 32'hB);
        check("t4_valid", 32'(valid), 32'h1);
        check("t4_busy", 32'(busy), 32'h0);

        // 5: reset in the middle of a frame while a word is pending
        send_bit(1'b0, 0, 1'b0, 1'b0);
        send_bit(1'b1, 0, 1'b0, 1'b0);
        send_bit(1'b1, 0, 1'b0, 1'b0);
        idle(1);
        check("t5_busy_mid", 32'(busy), 32'h1);
        do_reset();
        check("t5_all_zero", 32'({q, valid, busy, frame_err, overrun}), 32'h0);
        send_frame(4'h6, 1'b1, 0, 1'b0, 1'b0);
        idle(1);
        check("t5_q", 32'(q), 32'h6);
        check("t5_valid", 32'(valid), 32'h1);

        // 6: consume the word, idle line with stray acks, then clear racing a bad stop
        @(negedge clock);
        ack = 1'b1;
        idle(1);
        check("t6_acked", 32'(valid), 32'h0);
        for (int i = 0; i < 10; i++) send_bit(1'b1, 0, 1'b1, 1'b0);
        idle(1);
        check("t6_valid", 32'(valid), 32'h0);
        check("t6_busy", 32'(busy), 32'h0);
        check("t6_q", 32'(q), 32'h6);
        send_frame(4'h3, 1'b0, 0, 1'b0, 1'b1);
        idle(1);
        check("t6_set_wins", 32'(frame_err), 32'h1);
        check("t6_q_kept", 32'(q), 32'h6);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
